uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- UART receiver plus command-frame assembler upstream of the FSM/ALU/UART_TX path.
- Deserialises 8N1 bytes from the rx pin and assembles a 3-byte command frame: header with opcode, operand a, operand b.
- Presents a, b and opcode to the FSM inputs and pulses cmd_valid once per accepted frame.
- Bit timing matches UART_TX, so one CLKS_PER_BIT value serves both directions.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be at least 4 and even.
- TIMEOUT_BITS, 20: idle bit-times allowed between bytes of one frame before the partial frame is dropped.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- ena  input  1  block enable; low forces idle
- rx  input  1  serial input, idle high, asynchronous to clock
- a  output  8  operand a from the last accepted frame
- b  output  8  operand b from the last accepted frame
- opcode  output  3  opcode from the last accepted frame
- cmd_valid  output  1  one-cycle pulse when a, b and opcode update
- rx_busy  output  1  high from start-bit detect until end of stop bit
- frame_err  output  1  one-cycle pulse on a bad stop bit or a bad header

Behaviour:
- Reset: clock and reset as decided — reset is asynchronous, active-high; clock is clock.
- Reset values: a=0, b=0, opcode=0, cmd_valid=0, rx_busy=0, frame_err=0. rx synchroniser resets to 1. Bit FSM resets to IDLE. Frame index resets to 0.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- Bit FSM states:
  - IDLE: rxs=0 -> START, counter cleared, rx_busy=1.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. rxs=0 -> DATA. rxs=1 -> IDLE (glitch), no error, rx_busy=0.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rxs=1: byte good.
    - rxs=0: frame_err pulse, byte discarded, frame index -> 0.
    - Either way -> IDLE, rx_busy=0 on the next cycle.
- Frame assembler (consumes good bytes only):
  - Index 0: byte[7:3] must equal 5'b10100, i.e. 0xA0–0xA7. Match: hold byte[2:0] internally, index -> 1. Mismatch: frame_err pulse, index stays 0.
  - Index 1: hold byte as operand a, index -> 2.
  - Index 2: a, b and opcode outputs all update on the same edge. cmd_valid=1 for exactly that cycle. Index -> 0.
- Outputs a, b and opcode are never partially updated. They hold their values between frames.
- Latency: cmd_valid is high in the cycle immediately after the stop-bit sample of byte 2.
- Inter-byte timeout:
  - Counter runs while index is not 0 and the bit FSM is in IDLE.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT: index -> 0, no error pulse.
  - Counter clears on every start-bit detect.
- ena=0: bit FSM -> IDLE, index -> 0, timeout counter cleared, cmd_valid=0, rx_busy=0. a, b and opcode hold. The synchroniser keeps running.
- Reset mid-byte or mid-frame: all state returns to reset values immediately. The next start bit begins a fresh frame.
- rx held low indefinitely: after STOP fails with a frame_err, the FSM re-enters START on the next cycle. This repeats, one frame_err per byte-time.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined:
  - The frame is 4 bytes. Byte 3 = byte0 ^ byte1 ^ byte2.
  - Outputs update and cmd_valid fires only after a matching byte 3.
  - Mismatch: frame_err pulse, outputs unchanged, index -> 0.
  - The timeout also applies at index 3.
- Undefined: 3-byte frame as above. No checksum logic is synthesised.

Test Plan (all scenarios use CLKS_PER_BIT=16):
- Send 0xA2, 0x05, 0x03 -> one cmd_valid pulse, 1 cycle after the last stop sample; opcode=2, a=0x05, b=0x03; frame_err never asserts.
- Send 0x42, then 0xA1, 0x10, 0x20 -> frame_err pulse after 0x42, no cmd_valid for it; then cmd_valid with opcode=1, a=0x10, b=0x20.
- Pulse rx low for 4 clocks while idle -> rx_busy rises then falls; no frame_err, no cmd_valid.
- Send 0xA5, then a byte with stop bit 0, then 0xA6, 0x11, 0x22 -> one frame_err; cmd_valid only for opcode=6, a=0x11, b=0x22.
- Send 0xA3, 0x07, idle 25 bit-times, then 0xA4, 0x01, 0x02 -> no cmd_valid for the partial frame; cmd_valid with opcode=4, a=0x01, b=0x02.
- After a valid frame with a=0x05, assert reset mid-DATA of the next header -> outputs a, b, opcode become 0 and rx_busy=0; a following 0xA7, 0xFF, 0x80 gives opcode=7, a=0xFF, b=0x80. With UART_CMD_CHECKSUM_EN defined: 0xA7, 0xFF, 0x80, 0xD8 is accepted; a bad checksum gives frame_err and no cmd_valid.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver that assembles [0xA0|op, a, b] command frames for the FSM.
// Define UART_CMD_CHECKSUM_EN for a 4th byte carrying byte0^byte1^byte2.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] opcode,
  output logic       cmd_valid,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TMO_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    op_hold_q, op_hold_d;
  logic [7:0]    a_hold_q, a_hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          byte_vld, stop_bad;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    b_hold_q, b_hold_d;
  logic [7:0]    csum_q, csum_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      op_hold_q   <= '0;
      a_hold_q    <= '0;
      tmo_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      b_hold_q    <= '0;
      csum_q      <= '0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      op_hold_q   <= op_hold_d;
      a_hold_q    <= a_hold_d;
      tmo_q       <= tmo_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
      b_hold_q    <= b_hold_d;
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    op_hold_d   = op_hold_q;
    a_hold_d    = a_hold_q;
    tmo_d       = tmo_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    byte_vld    = 1'b0;
    stop_bad    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    b_hold_d    = b_hold_q;
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          byte_vld = rxs_q;
          stop_bad = !rxs_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout only ticks while a frame is partially assembled.
    if (state_q == S_IDLE && !rxs_q) begin
      tmo_d = '0;
    end else if (idx_q == 2'd0) begin
      tmo_d = '0;
    end else if (state_q == S_IDLE) begin
      if (tmo_q == TMO_M1) begin
        tmo_d = '0;
        idx_d = 2'd0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (stop_bad) begin
      frame_err_d = 1'b1;
      idx_d       = 2'd0;
    end else if (byte_vld) begin
      case (idx_q)
        2'd0: begin
          if (shift_q[7:3] == 5'b10100) begin
            op_hold_d = shift_q[2:0];
            idx_d     = 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
            csum_d    = shift_q;
`endif
          end else begin
            frame_err_d = 1'b1;
            idx_d       = 2'd0;
          end
        end
        2'd1: begin
          a_hold_d = shift_q;
          idx_d    = 2'd2;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d   = csum_q ^ shift_q;
`endif
        end
`ifdef UART_CMD_CHECKSUM_EN
        2'd2: begin
          b_hold_d = shift_q;
          csum_d   = csum_q ^ shift_q;
          idx_d    = 2'd3;
        end
        2'd3: begin
          idx_d = 2'd0;
          if (shift_q == csum_q) begin
            a_d         = a_hold_q;
            b_d         = b_hold_q;
            op_d        = op_hold_q;
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
`else
        2'd2: begin
          a_d         = a_hold_q;
          b_d         = shift_q;
          op_d        = op_hold_q;
          cmd_valid_d = 1'b1;
          idx_d       = 2'd0;
        end
`endif
        default: idx_d = 2'd0;
      endcase
    end

    if (!ena) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      idx_d       = 2'd0;
      tmo_d       = '0;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign opcode    = op_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = ena && (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed serial frames, expected commands queued and checked by a monitor.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
  localparam int CPB = 16;
  // Start-bit fall to cmd_valid visible: 2 sync + 1 detect + CPB/2 + 9*CPB cycles.
  localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic       cmd_valid, rx_busy, frame_err;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fe_cnt = 0;
  int   cmd_cnt = 0;
  cmd_t dummy;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clock(clock), .reset(reset), .ena(ena), .rx(rx),
    .a(a), .b(b), .opcode(opcode),
    .cmd_valid(cmd_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (cmd_valid === 1'b1) begin
      cmd_t e;
      cmd_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd: got op=%0d a=0x%0h b=0x%0h, expected no command", opcode, a, b);
      end else begin
        e = exp_q.pop_front();
        check("cmd_opcode", {29'd0, opcode}, {29'd0, e.op});
        check("cmd_a", {24'd0, a}, {24'd0, e.a});
        check("cmd_b", {24'd0, b}, {24'd0, e.b});
        check("cmd_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic push, input cmd_t e);
    cmd_t x;
    @(negedge clock);
    rx = 1'b0;
    if (push) begin
      x = e;
      x.cyc = cyc + LAT;
      exp_q.push_back(x);
    end
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] av, input logic [7:0] bv);
    cmd_t e;
    e.op = h[2:0]; e.a = av; e.b = bv; e.cyc = 0;
    send_byte(h, 1'b1, 1'b0, e);
    send_byte(av, 1'b1, 1'b0, e);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(bv, 1'b1, 1'b0, e);
    send_byte(h ^ av ^ bv, 1'b1, 1'b1, e);
`else
    send_byte(bv, 1'b1, 1'b1, e);
`endif
  endtask

  initial begin
    dummy = '{op: 3'd0, a: 8'd0, b: 8'd0, cyc: 0};
    repeat (3) @(negedge clock);
    check("rst_a", {24'd0, a}, 32'h0);
    check("rst_b", {24'd0, b}, 32'h0);
    check("rst_opcode", {29'd0, opcode}, 32'h0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'h0);
    check("rst_frame_err", {31'd0, frame_err}, 32'h0);
    reset = 1'b0;
    ena = 1'b1;
    repeat (5) @(negedge clock);

    send_frame(8'hA2, 8'h05, 8'h03);
    check("t1_no_frame_err", fe_cnt, 0);
    check("t1_hold_a", {24'd0, a}, 32'h05);

    send_byte(8'h42, 1'b1, 1'b0, dummy);
    check("t2_bad_header_err", fe_cnt, 1);
    send_frame(8'hA1, 8'h10, 8'h20);
    check("t2_err_count", fe_cnt, 1);

    @(negedge clock);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    check("t3_glitch_busy_high", {31'd0, rx_busy}, 32'h1);
    repeat (20) @(negedge clock);
    check("t3_glitch_busy_low", {31'd0, rx_busy}, 32'h0);
    check("t3_glitch_no_err", fe_cnt, 1);

    send_byte(8'hA5, 1'b1, 1'b0, dummy);
    send_byte(8'h33, 1'b0, 1'b0, dummy);
    check("t4_stop_err", fe_cnt, 2);
    send_frame(8'hA6, 8'h11, 8'h22);
    check("t4_err_count", fe_cnt, 2);

    send_byte(8'hA3, 1'b1, 1'b0, dummy);
    send_byte(8'h07, 1'b1, 1'b0, dummy);
    repeat (25 * CPB) @(negedge clock);
    send_frame(8'hA4, 8'h01, 8'h02);
    check("t5_timeout_no_err", fe_cnt, 2);

    send_byte(8'hA3, 1'b1, 1'b0, dummy);
    ena = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_ena_busy_low", {31'd0, rx_busy}, 32'h0);
    ena = 1'b1;
    send_frame(8'hA5, 8'h33, 8'h44);

    send_frame(8'hA2, 8'h05, 8'h03);
    @(negedge clock);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    check("t7_busy_mid_data", {31'd0, rx_busy}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    check("t7_rst_a", {24'd0, a}, 32'h0);
    check("t7_rst_b", {24'd0, b}, 32'h0);
    check("t7_rst_opcode", {29'd0, opcode}, 32'h0);
    check("t7_rst_busy", {31'd0, rx_busy}, 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send_frame(8'hA7, 8'hFF, 8'h80);
    check("t7_hold_opcode", {29'd0, opcode}, 32'h7);
    check("t7_err_count", fe_cnt, 2);

`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hA1, 1'b1, 1'b0, dummy);
    send_byte(8'h02, 1'b1, 1'b0, dummy);
    send_byte(8'h03, 1'b1, 1'b0, dummy);
    send_byte(8'h00, 1'b1, 1'b0, dummy);
    check("t8_bad_csum_err", fe_cnt, 3);
    check("t8_hold_b", {24'd0, b}, 32'h80);
`endif

    repeat (50) @(negedge clock);
    check("pending_expected", exp_q.size(), 0);
    check("cmd_total", cmd_cnt, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
